// File: rtl/accel_cpu_cpu_debug_mon_access_if.sv
// Bundles the JTAG-side strobes, debug-RAM request/return and monitor results of the OCI memory monitor.
// slave: the monitor block; master: the environment driving it.
interface accel_cpu_cpu_debug_mon_access_if;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_rd;
  logic        ram_wr;
  logic [31:0] ram_rdata;
  logic        ram_rvalid;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  modport slave (
    input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    input  ram_rdata, ram_rvalid,
    output ram_addr, ram_wdata, ram_rd, ram_wr,
    output MonDReg, monitor_ready, monitor_error
  );

  modport master (
    output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    output ram_rdata, ram_rvalid,
    input  ram_addr, ram_wdata, ram_rd, ram_wr,
    input  MonDReg, monitor_ready, monitor_error
  );
endinterface

// File: rtl/accel_cpu_cpu_debug_mon_access.sv
// Debug monitor access engine: turns JTAG strobes into single debug-RAM reads/writes with auto-increment.
// Optional macro ACCEL_DEBUG_MON_TIMEOUT_EN adds a 15-cycle read timeout that reports monitor_error.
//
// state   | meaning
// IDLE    | ready for a strobe, monitor_ready high
// RD_REQ  | one-cycle ram_rd pulse at MonAReg
// RD_WAIT | waiting for ram_rvalid
// WR      | one-cycle ram_wr pulse at MonAReg
module accel_cpu_cpu_debug_mon_access (
  input  logic                                  clk,
  input  logic                                  reset_n,
  accel_cpu_cpu_debug_mon_access_if.slave       mon
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR} state_e;

  state_e      state_q, state_d;
  logic [7:0]  mon_a_q, mon_a_d;
  logic [31:0] mon_d_q, mon_d_d;
  logic [31:0] wdata_q, wdata_d;
  logic        any_strobe;

  assign any_strobe = mon.take_action_ocimem_a | mon.take_no_action_ocimem_a |
                      mon.take_action_ocimem_b;

`ifdef ACCEL_DEBUG_MON_TIMEOUT_EN
  logic [3:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    wdata_d = wdata_q;
`ifdef ACCEL_DEBUG_MON_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ACCEL_DEBUG_MON_TIMEOUT_EN
        if (any_strobe) err_d = 1'b0;
`endif
        // Priority: address load > read-next > write; losing strobes vanish.
        if (mon.take_action_ocimem_a) begin
          mon_a_d = mon.jdo[25:18];
          if (mon.jdo[35]) state_d = RD_REQ;
        end else if (mon.take_no_action_ocimem_a) begin
          state_d = RD_REQ;
        end else if (mon.take_action_ocimem_b) begin
          wdata_d = mon.jdo[34:3];
          state_d = WR;
        end
      end
      RD_REQ: begin
        state_d = RD_WAIT;
`ifdef ACCEL_DEBUG_MON_TIMEOUT_EN
        tmo_cnt_d = 4'd0;
`endif
      end
      RD_WAIT: begin
        if (mon.ram_rvalid) begin
          mon_d_d = mon.ram_rdata;
          mon_a_d = mon_a_q + 8'd1;
          state_d = IDLE;
        end
`ifdef ACCEL_DEBUG_MON_TIMEOUT_EN
        // Count 14 marks the 15th waiting cycle.
        else if (tmo_cnt_q == 4'd14) begin
          mon_d_d = 32'hDEADBEEF;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
`endif
      end
      WR: begin
        mon_a_d = mon_a_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mon_a_q <= 8'd0;
      mon_d_q <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef ACCEL_DEBUG_MON_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
  assign mon.monitor_error = err_q;
`else
  logic unused_strobe;
  assign unused_strobe     = any_strobe;
  assign mon.monitor_error = 1'b0;
`endif

  assign mon.ram_addr      = mon_a_q;
  assign mon.ram_wdata     = wdata_q;
  assign mon.ram_rd        = (state_q == RD_REQ);
  assign mon.ram_wr        = (state_q == WR);
  assign mon.MonDReg       = mon_d_q;
  assign mon.monitor_ready = (state_q == IDLE);

  logic unused_jdo;
  assign unused_jdo = ^{mon.jdo[37:36], mon.jdo[2:0]};

endmodule

// File: tb/tb_accel_cpu_cpu_debug_mon_access.sv
// Self-checking bench for the debug monitor access engine: directed vector table,
// multi-cycle corner sequences and a randomized run against a transaction-level model.
module tb_accel_cpu_cpu_debug_mon_access;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  accel_cpu_cpu_debug_mon_access_if bus();

  accel_cpu_cpu_debug_mon_access dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mon     (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] mem [256];

  typedef struct {
    bit          a, n, b, rd35;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata;
    bit          exp_rd, exp_wr;
    logic [7:0]  exp_pulse_addr, exp_after;
    logic [31:0] exp_mond;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_strobes(input bit a, input bit n, input bit b);
    bus.take_action_ocimem_a    = a;
    bus.take_no_action_ocimem_a = n;
    bus.take_action_ocimem_b    = b;
  endtask

  task automatic strobe(input bit a, input bit n, input bit b, input logic [37:0] j);
    bus.jdo = j;
    set_strobes(a, n, b);
    tick();
    set_strobes(0, 0, 0);
  endtask

  function automatic logic [37:0] ajdo(input bit r, input logic [7:0] ad);
    logic [37:0] j;
    j = '0;
    j[35] = r;
    j[25:18] = ad;
    return j;
  endfunction

  function automatic logic [37:0] wjdo(input logic [31:0] wd);
    logic [37:0] j;
    j = '0;
    j[34:3] = wd;
    return j;
  endfunction

  // Called in the ram_rd cycle; returns data lat cycles later, counting any further ram_rd/ram_wr.
  task automatic rd_complete(input int lat, input logic [31:0] data, input bit noise,
                             output int extra);
    extra = 0;
    for (int i = 0; i < lat; i++) begin
      if (noise) set_strobes($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      bus.jdo = {$urandom, $urandom};
      tick();
      set_strobes(0, 0, 0);
      if (bus.ram_rd || bus.ram_wr) extra++;
    end
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = data;
    tick();
    bus.ram_rvalid = 1'b0;
    bus.ram_rdata  = 32'h0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, bus.monitor_ready, 1);
    check({tag, "_err"},   bus.monitor_error, 0);
    check({tag, "_addr"},  bus.ram_addr, 0);
    check({tag, "_mond"},  bus.MonDReg, 0);
    check({tag, "_wdata"}, bus.ram_wdata, 0);
    check({tag, "_rd"},    bus.ram_rd, 0);
    check({tag, "_wr"},    bus.ram_wr, 0);
  endtask

  initial begin
    int extra;
    logic [7:0]  addr_m;
    logic [31:0] mond_m;

    bus.jdo = '0;
    set_strobes(0, 0, 0);
    bus.ram_rdata = '0;
    bus.ram_rvalid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    vt[0]  = '{1,0,0,0, 8'h20, 32'h0,        32'h0,        0,0, 8'h20, 8'h20, 32'h0};
    vt[1]  = '{1,0,0,1, 8'h10, 32'h0,        32'hCAFEF00D, 1,0, 8'h10, 8'h11, 32'hCAFEF00D};
    vt[2]  = '{0,1,0,0, 8'h00, 32'h0,        32'h0BADF00D, 1,0, 8'h11, 8'h12, 32'h0BADF00D};
    vt[3]  = '{0,0,1,0, 8'h00, 32'hA5A55A5A, 32'h0,        0,1, 8'h12, 8'h13, 32'h0BADF00D};
    vt[4]  = '{1,0,1,1, 8'h40, 32'h0,        32'h600DCAFE, 1,0, 8'h40, 8'h41, 32'h600DCAFE};
    vt[5]  = '{1,1,0,0, 8'h7F, 32'h0,        32'h0,        0,0, 8'h7F, 8'h7F, 32'h600DCAFE};
    vt[6]  = '{0,1,1,0, 8'h00, 32'h13579BDF, 32'h2468ACE0, 1,0, 8'h7F, 8'h80, 32'h2468ACE0};
    vt[7]  = '{1,0,0,0, 8'hFF, 32'h0,        32'h0,        0,0, 8'hFF, 8'hFF, 32'h2468ACE0};
    vt[8]  = '{0,0,1,0, 8'h00, 32'h12345678, 32'h0,        0,1, 8'hFF, 8'h00, 32'h2468ACE0};
    vt[9]  = '{1,0,0,1, 8'hFF, 32'h0,        32'h11223344, 1,0, 8'hFF, 8'h00, 32'h11223344};
    vt[10] = '{0,0,0,0, 8'h00, 32'h0,        32'h0,        0,0, 8'h00, 8'h00, 32'h11223344};

    tick();
    tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();

    // Directed vector table, each vector starting and ending in IDLE.
    foreach (vt[i]) begin
      strobe(vt[i].a, vt[i].n, vt[i].b,
             vt[i].a ? ajdo(vt[i].rd35, vt[i].addr) : wjdo(vt[i].wdata));
      check($sformatf("v%0d_rd", i), bus.ram_rd, vt[i].exp_rd);
      check($sformatf("v%0d_wr", i), bus.ram_wr, vt[i].exp_wr);
      check($sformatf("v%0d_pulse_addr", i), bus.ram_addr, vt[i].exp_pulse_addr);
      check($sformatf("v%0d_busy_ready", i), bus.monitor_ready, !(vt[i].exp_rd || vt[i].exp_wr));
      if (vt[i].exp_wr) begin
        check($sformatf("v%0d_wdata", i), bus.ram_wdata, vt[i].wdata);
        tick();
      end
      if (vt[i].exp_rd) begin
        rd_complete(3, vt[i].rdata, 0, extra);
        check($sformatf("v%0d_extra_pulses", i), extra, 0);
      end
      check($sformatf("v%0d_ready", i), bus.monitor_ready, 1);
      check($sformatf("v%0d_addr_after", i), bus.ram_addr, vt[i].exp_after);
      check($sformatf("v%0d_mond", i), bus.MonDReg, vt[i].exp_mond);
      check($sformatf("v%0d_err", i), bus.monitor_error, 0);
    end

    // Strobe during RD_WAIT dropped; stray rvalid in IDLE ignored.
    strobe(1, 0, 0, ajdo(1, 8'h30));
    tick();
    set_strobes(0, 1, 0);
    tick();
    set_strobes(0, 0, 0);
    extra = (bus.ram_rd || bus.ram_wr) ? 1 : 0;
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 32'h87654321;
    tick();
    bus.ram_rvalid = 1'b0;
    tick();
    if (bus.ram_rd) extra++;
    check("drop_extra_pulses", extra, 0);
    check("drop_mond", bus.MonDReg, 32'h87654321);
    check("drop_addr", bus.ram_addr, 8'h31);
    check("drop_ready", bus.monitor_ready, 1);
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 32'hFFFF0000;
    tick();
    bus.ram_rvalid = 1'b0;
    check("idle_rvalid_mond", bus.MonDReg, 32'h87654321);
    check("idle_rvalid_addr", bus.ram_addr, 8'h31);

    // Read with no response.
    strobe(0, 1, 0, '0);
    check("tmo_rd", bus.ram_rd, 1);
    for (int i = 0; i < 15; i++) tick();
    check("tmo_busy15", bus.monitor_ready, 0);
    tick();
`ifdef ACCEL_DEBUG_MON_TIMEOUT_EN
    check("tmo_ready", bus.monitor_ready, 1);
    check("tmo_mond", bus.MonDReg, 32'hDEADBEEF);
    check("tmo_err", bus.monitor_error, 1);
    check("tmo_addr", bus.ram_addr, 8'h31);
    strobe(1, 0, 0, ajdo(0, 8'h50));
    check("tmo_err_clear", bus.monitor_error, 0);
    check("tmo_after_addr", bus.ram_addr, 8'h50);
`else
    for (int i = 0; i < 24; i++) tick();
    check("notmo_busy", bus.monitor_ready, 0);
    check("notmo_err", bus.monitor_error, 0);
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 32'h55AA55AA;
    tick();
    bus.ram_rvalid = 1'b0;
    check("notmo_ready", bus.monitor_ready, 1);
    check("notmo_mond", bus.MonDReg, 32'h55AA55AA);
    check("notmo_addr", bus.ram_addr, 8'h32);
`endif

    // Reset mid-read, late rvalid after release.
    strobe(0, 0, 1, wjdo(32'hC0FFEE11));
    tick();
    strobe(1, 0, 0, ajdo(1, 8'h22));
    tick();
    reset_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    #2;
    reset_n = 1'b1;
    tick();
    tick();
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 32'hBAD0BAD0;
    tick();
    bus.ram_rvalid = 1'b0;
    tick();
    check_reset_values("late_rvalid");

    // Randomized transactions against a transaction-level model.
    addr_m = 8'h00;
    mond_m = 32'h0;
    for (int t = 0; t < 300; t++) begin
      logic [2:0]  mask;
      logic [37:0] j;
      int          kind;
      mask = 3'($urandom_range(0, 7));
      j = {$urandom, $urandom};
      if (mask[0]) begin
        addr_m = j[25:18];
        kind = j[35] ? 1 : 0;
      end else if (mask[1]) kind = 1;
      else if (mask[2]) kind = 2;
      else kind = 0;
      strobe(mask[0], mask[1], mask[2], j);
      check("rnd_rd", bus.ram_rd, kind == 1);
      check("rnd_wr", bus.ram_wr, kind == 2);
      if (kind != 0) check("rnd_pulse_addr", bus.ram_addr, addr_m);
      if (kind == 1) begin
        rd_complete($urandom_range(1, 5), mem[addr_m], 1, extra);
        check("rnd_extra", extra, 0);
        mond_m = mem[addr_m];
        addr_m = addr_m + 8'd1;
      end else if (kind == 2) begin
        check("rnd_wdata", bus.ram_wdata, j[34:3]);
        mem[addr_m] = j[34:3];
        addr_m = addr_m + 8'd1;
        tick();
      end
      check("rnd_ready", bus.monitor_ready, 1);
      check("rnd_addr", bus.ram_addr, addr_m);
      check("rnd_mond", bus.MonDReg, mond_m);
      check("rnd_err", bus.monitor_error, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
